// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq
//   Multi-cycle floating-point add/subtract on a small operand register bank.
//   Number format: {sign, exp[EXP_W], frac[FRAC_W]}, where value = (-1)^s * 0.f * 2^e.
//   The exponent is unsigned with no bias, and the leading 1 of frac is explicit.
//   The operation steps through SORT -> ALIGN -> ADD -> NORM. NORM repeats while the
//   fraction still needs left shifts.
// Ports
//   clk, reset_n         rising-edge clock, asynchronous active-low reset
//   load/load_idx/din    bank write (accepted only when idle)
//   start/idx_a/idx_b    start bank[idx_a] +/- bank[idx_b] (accepted only when idle)
//   op_sub               1: a - b, 0: a + b
//   wb_en/wb_idx         write the result back into the bank on completion
//   busy                 operation in flight
//   done                 one-cycle pulse with a fresh result
//   result/ovf/zero      last result and its flags, held until the next completion
module fp_addsub_seq #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8,
  parameter int NREG   = 2,
  localparam int IW    = $clog2(NREG),
  localparam int W     = 1 + EXP_W + FRAC_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  input  logic [W-1:0]  din,
  input  logic          start,
  input  logic [IW-1:0] idx_a,
  input  logic [IW-1:0] idx_b,
  input  logic          op_sub,
  input  logic          wb_en,
  input  logic [IW-1:0] wb_idx,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          ovf,
  output logic          zero
);

  typedef enum logic [2:0] {S_IDLE, S_SORT, S_ALIGN, S_ADD, S_NORM} state_t;

  state_t state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic              sub_q, sub_d, wb_en_q, wb_en_d;
  logic [IW-1:0]     wb_idx_q, wb_idx_d;
  logic              sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic [EXP_W-1:0]  exp_q, exp_d, es_q, es_d;
  logic [FRAC_W-1:0] fb_q, fb_d, fs_q, fs_d;
  logic [FRAC_W:0]   sum_q, sum_d;
  logic [W-1:0]      result_q, result_d;
  logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [W-1:0]      bank_rd [NREG];
  logic [W-1:0]      rd_a, rd_b;
  logic              load_we, wb_we;
  logic [EXP_W-1:0]  exp_diff;

  assign load_we  = load && (state_q == S_IDLE);
  assign exp_diff = exp_q - es_q;

  // An index that matches no entry (only possible for non-power-of-2 NREG) reads as 0.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx_a == IW'(i)) rd_a = bank_rd[i];
      if (idx_b == IW'(i)) rd_b = bank_rd[i];
    end
  end

  // Operand bank. Each entry is one register. An out-of-range write index matches no entry,
  // so that write is dropped.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_bank
    logic [W-1:0] entry_q, entry_d;
    always_comb begin
      entry_d = entry_q;
      if (load_we && (load_idx == IW'(gi))) entry_d = din;
      if (wb_we && (wb_idx_q == IW'(gi)))   entry_d = result_d;
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) entry_q <= '0;
      else          entry_q <= entry_d;
    end
    assign bank_rd[gi] = entry_q;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    wb_en_d   = wb_en_q;
    wb_idx_d  = wb_idx_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    exp_d     = exp_q;
    es_d      = es_q;
    fb_d      = fb_q;
    fs_d      = fs_q;
    sum_d     = sum_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    wb_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // The operands are read from registers, so a load in this same cycle is not visible yet.
          a_d      = rd_a;
          b_d      = rd_b;
          sub_d    = op_sub;
          wb_en_d  = wb_en;
          wb_idx_d = wb_idx;
          busy_d   = 1'b1;
          state_d  = S_SORT;
        end
      end
      S_SORT: begin
        eff_sub_d = a_q[W-1] ^ b_q[W-1] ^ sub_q;
        // Order the operands by magnitude {exp, frac}. On a tie, a is the big operand.
        if (a_q[W-2:0] >= b_q[W-2:0]) begin
          sign_d = a_q[W-1];
          exp_d  = a_q[W-2:FRAC_W];
          fb_d   = a_q[FRAC_W-1:0];
          es_d   = b_q[W-2:FRAC_W];
          fs_d   = b_q[FRAC_W-1:0];
        end else begin
          sign_d = b_q[W-1] ^ sub_q;
          exp_d  = b_q[W-2:FRAC_W];
          fb_d   = b_q[FRAC_W-1:0];
          es_d   = a_q[W-2:FRAC_W];
          fs_d   = a_q[FRAC_W-1:0];
        end
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
        // Truncating alignment: bits shifted out are lost, and a wide gap aligns to zero.
        if (32'(exp_diff) >= FRAC_W) fs_d = '0;
        else                         fs_d = fs_q >> exp_diff;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (eff_sub_q) sum_d = {1'b0, fb_q} - {1'b0, fs_q};
        else           sum_d = {1'b0, fb_q} + {1'b0, fs_q};
        state_d = S_NORM;
      end
      S_NORM: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        zero_d  = 1'b0;
        wb_we   = wb_en_q;
        if (sum_q == '0) begin
          result_d = '0;
          zero_d   = 1'b1;
        end else if (sum_q[FRAC_W]) begin
          if (exp_q == '1) begin
            result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
            ovf_d    = 1'b1;
          end else begin
            result_d = {sign_q, exp_q + 1'b1, sum_q[FRAC_W:1]};
          end
        end else if (sum_q[FRAC_W-1]) begin
          result_d = {sign_q, exp_q, sum_q[FRAC_W-1:0]};
        end else if (exp_q == '0) begin
          result_d = '0;
          zero_d   = 1'b1;
        end else begin
          // Shift left one more place. The operation does not complete this cycle.
          sum_d   = {sum_q[FRAC_W-1:0], 1'b0};
          exp_d   = exp_q - 1'b1;
          state_d = S_NORM;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ovf_d   = ovf_q;
          zero_d  = zero_q;
          wb_we   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_idx_q  <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      es_q      <= '0;
      fb_q      <= '0;
      fs_q      <= '0;
      sum_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_q     <= sub_d;
      wb_en_q   <= wb_en_d;
      wb_idx_q  <= wb_idx_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      exp_q     <= exp_d;
      es_q      <= es_d;
      fb_q      <= fb_d;
      fs_q      <= fs_d;
      sum_q     <= sum_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule
